reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Hazard scoreboard that drives the issue side of the pipelined MIPS register file.
- Tracks outstanding writes per architectural register, from issue (ID stage) to writeback (WB stage, the RegWrite/WriteR port of the register file).
- Stalls any issuing instruction whose sources or destination are not yet safe.
- The register file writes on posedge and reads on negedge, so a same-cycle writeback resolves a hazard without a stall.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero and never tracked.
- AW, 5, register index width.
- CW, 2, per-register pending-count width; at most 2^CW-1 writes outstanding per register.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Rst  input  1  asynchronous, active-high reset.
- Flush  input  1  synchronous clear of all pending counts (branch/exception squash).
- IssueValid  input  1  an instruction is presented for issue this cycle.
- IssueUse1  input  1  the instruction reads IssueR1.
- IssueUse2  input  1  the instruction reads IssueR2.
- IssueR1  input  AW  source register 1 (rs).
- IssueR2  input  AW  source register 2 (rt).
- IssueRegWrite  input  1  the instruction will write a destination register.
- IssueDest  input  AW  destination register.
- WbRegWrite  input  1  writeback is writing the register file this cycle.
- WbWriteR  input  AW  writeback destination register.
- Stall  output  1  combinational; 1 = hold the instruction in ID, do not issue.
- Busy  output  NREG  registered; bit i = 1 when cnt[i] != 0.
- Underflow  output  1  registered, sticky; writeback arrived for a register with no pending write.

Behaviour:
- State: cnt[1..NREG-1], each CW bits. cnt[0] does not exist; reads of index 0 return 0.
- Reset (async, Rst=1): all cnt=0, Busy=0, Underflow=0. Stall is combinational and evaluates to 0 while all cnt=0 and no saturation.
- Resolve term for register r: resolves(r) = WbRegWrite & (WbWriteR==r) & (r!=0).
- Source hazard for source s with use bit u: hz(s) = u & (s!=0) & (cnt[s]!=0) & !(resolves(s) & cnt[s]==1).
  - A register with 2 or more pending writes still stalls even when a writeback to it occurs this cycle.
- Destination saturation: sat = IssueRegWrite & (IssueDest!=0) & (cnt[IssueDest]==2^CW-1) & !resolves(IssueDest).
- Stall = IssueValid & !Flush & (hz(IssueR1,IssueUse1) | hz(IssueR2,IssueUse2) | sat).
- Issue accept: acc = IssueValid & !Stall & !Flush.
- Increment condition: inc(r) = acc & IssueRegWrite & (IssueDest==r) & (r!=0).
- Per-register update each posedge, in priority order:
  1. Flush: cnt=0.
  2. inc & dec (dec = resolves(r) & cnt[r]!=0): no change.
  3. inc only: +1.
  4. dec only: -1.
- Writeback to a register with cnt==0 (r!=0): cnt unchanged; set Underflow=1. Underflow clears only on Rst; Flush does not clear it.
- Writes to register 0 (issue or writeback) have no effect and never set Underflow.
- Busy is updated from the next-state counts; 1-cycle latency from the issue/WB event.
- Reset mid-operation: immediately clears all state regardless of Clk.

Decomposition:
- Shared package mips_pkg:
  - localparams NREG, AW, REG_ZERO=0.
  - Register-index typedef reg_idx_t (AW bits).
- One natural sub-module, sb_counter: a single CW-bit up/down counter with Flush, inc, dec, and an underflow pulse output.
  - Instantiated NREG-1 times via generate.
- The top level holds the hazard/stall logic and the Underflow OR-reduce.

Test Plan:
1. Rst pulse, then idle: Busy=0, Stall=0, Underflow=0. Issue with R1=3, R2=4, uses=1: Stall=0.
2. Issue with IssueRegWrite=1, Dest=5, accepted → next cycle Busy[5]=1. Issue with R1=5, Use1=1: Stall=1 each cycle until WbRegWrite=1, WbWriteR=5.
   - In that writeback cycle Stall=0 (same-cycle bypass); next cycle Busy[5]=0.
3. Issue writes to Dest=7 three times (CW=2): cnt=3. A fourth issue to Dest=7: Stall=1. The same fourth issue during a cycle with WbWriteR=7: accepted, cnt remains 3.
4. Issue with Dest=0, R1=0, Use1=1: never stalls, Busy[0]=0. WbWriteR=0 with WbRegWrite=1: Underflow stays 0.
5. WbRegWrite=1, WbWriteR=9 while cnt[9]=0 → Underflow=1 next cycle, stays 1 through Flush; cleared only by Rst.
6. Pending on registers 2, 6, 31, then Flush=1 with IssueValid=1 and Dest=2 → Stall=0, no issue accepted, all Busy=0 next cycle. Rst asserted between clock edges → Busy=0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice.
// Holds the register-file geometry, the register index type and the
// pending-write counter geometry used by the issue scoreboard.
package mips_pkg;

    // Number of architectural registers and index width.
    localparam int NREG = 32;
    localparam int AW   = 5;

    // Index of a register file entry.
    typedef logic [AW-1:0] reg_idx_t;

    // Register 0 is hardwired to zero and is never tracked.
    localparam reg_idx_t REG_ZERO = '0;

    // Pending-write counter width and its saturation value.
    localparam int CW = 2;
    localparam logic [CW-1:0] CNT_MAX = '1;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: pending-write counter for one architectural register.
// Ports:
//   Clk          - system clock
//   Rst          - asynchronous active-high reset
//   Flush        - synchronous clear of the count
//   Inc          - an accepted issue targets this register
//   Wb           - writeback targets this register this cycle
//   Count        - current number of outstanding writes
//   Busy         - registered flag, 1 when Count is non-zero
//   UnderflowEvt - combinational pulse: writeback seen with nothing pending
module sb_counter
    import mips_pkg::*;
(
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Flush,
    input  logic          Inc,
    input  logic          Wb,
    output logic [CW-1:0] Count,
    output logic          Busy,
    output logic          UnderflowEvt
);

    logic          dec;
    logic [CW-1:0] nextCount;

    // A writeback only retires a write if one is outstanding; a writeback
    // with nothing pending is reported rather than wrapping the count.
    // An issue and a retirement in the same cycle cancel each other out.
    always_comb begin
        dec          = Wb && (Count != '0);
        UnderflowEvt = Wb && (Count == '0);
        nextCount    = Count;
        if (Flush) begin
            nextCount = '0;
        end else if (Inc && !dec) begin
            nextCount = Count + CW'(1);
        end else if (dec && !Inc) begin
            nextCount = Count - CW'(1);
        end
    end

    // Busy is taken from the next count so it tracks Count exactly.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Count <= '0;
            Busy  <= 1'b0;
        end else begin
            Count <= nextCount;
            Busy  <= (nextCount != '0);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-side hazard scoreboard for the MIPS register file.
// Counts outstanding writes per register between ID issue and WB, and stalls
// issue while a source is still pending or the destination counter is full.
// The register file writes on posedge and reads on negedge, so a writeback
// that retires the last pending write in the same cycle clears the hazard.
// Ports:
//   Clk, Rst                  - clock, asynchronous active-high reset
//   Flush                     - squash: clear every pending count
//   IssueValid                - instruction presented in ID
//   IssueUse1/2, IssueR1/2    - source use flags and indices
//   IssueRegWrite, IssueDest  - destination write flag and index
//   WbRegWrite, WbWriteR      - writeback port of the register file
//   Stall                     - combinational, hold the instruction in ID
//   Busy                      - registered, bit i set while writes to i pending
//   Underflow                 - registered sticky writeback-without-issue flag
module reg_scoreboard
    import mips_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Flush,
    input  logic            IssueValid,
    input  logic            IssueUse1,
    input  logic            IssueUse2,
    input  reg_idx_t        IssueR1,
    input  reg_idx_t        IssueR2,
    input  logic            IssueRegWrite,
    input  reg_idx_t        IssueDest,
    input  logic            WbRegWrite,
    input  reg_idx_t        WbWriteR,
    output logic            Stall,
    output logic [NREG-1:0] Busy,
    output logic            Underflow
);

    logic [CW-1:0]   cnt [NREG];
    logic [NREG-1:0] underflowEvt;
    logic            accept;
    logic            resR1;
    logic            resR2;
    logic            resDest;
    logic            hz1;
    logic            hz2;
    logic            sat;

    // Register 0 has no counter; it reads as never pending.
    assign cnt[0]          = '0;
    assign Busy[0]         = 1'b0;
    assign underflowEvt[0] = 1'b0;

    // A source is only safe to bypass when the writeback in flight is the
    // last outstanding write to it; with two or more pending, a later
    // producer is still outstanding and the read must wait.
    always_comb begin
        resR1   = WbRegWrite && (WbWriteR == IssueR1)   && (IssueR1   != REG_ZERO);
        resR2   = WbRegWrite && (WbWriteR == IssueR2)   && (IssueR2   != REG_ZERO);
        resDest = WbRegWrite && (WbWriteR == IssueDest) && (IssueDest != REG_ZERO);
        hz1 = IssueUse1 && (IssueR1 != REG_ZERO) && (cnt[IssueR1] != '0)
              && !(resR1 && (cnt[IssueR1] == CW'(1)));
        hz2 = IssueUse2 && (IssueR2 != REG_ZERO) && (cnt[IssueR2] != '0)
              && !(resR2 && (cnt[IssueR2] == CW'(1)));
        sat = IssueRegWrite && (IssueDest != REG_ZERO)
              && (cnt[IssueDest] == CNT_MAX) && !resDest;
        Stall  = IssueValid && !Flush && (hz1 || hz2 || sat);
        accept = IssueValid && !Stall && !Flush;
    end

    for (genvar i = 1; i < NREG; i++) begin : gCnt
        sb_counter uCnt (
            .Clk          (Clk),
            .Rst          (Rst),
            .Flush        (Flush),
            .Inc          (accept && IssueRegWrite && (IssueDest == reg_idx_t'(i))),
            .Wb           (WbRegWrite && (WbWriteR == reg_idx_t'(i))),
            .Count        (cnt[i]),
            .Busy         (Busy[i]),
            .UnderflowEvt (underflowEvt[i])
        );
    end

    // Underflow is sticky across Flush; only reset clears it.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Underflow <= 1'b0;
        end else if (|underflowEvt) begin
            Underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios with literal
// expectations followed by randomized traffic against a pending-count model.
module tb_reg_scoreboard;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Flush;
    logic        IssueValid;
    logic        IssueUse1;
    logic        IssueUse2;
    logic [4:0]  IssueR1;
    logic [4:0]  IssueR2;
    logic        IssueRegWrite;
    logic [4:0]  IssueDest;
    logic        WbRegWrite;
    logic [4:0]  WbWriteR;
    logic        Stall;
    logic [31:0] Busy;
    logic        Underflow;

    int pendM [32];
    bit underflowM;
    bit checking;
    int checkCount;
    int passCount;

    reg_scoreboard dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Flush         (Flush),
        .IssueValid    (IssueValid),
        .IssueUse1     (IssueUse1),
        .IssueUse2     (IssueUse2),
        .IssueR1       (IssueR1),
        .IssueR2       (IssueR2),
        .IssueRegWrite (IssueRegWrite),
        .IssueDest     (IssueDest),
        .WbRegWrite    (WbRegWrite),
        .WbWriteR      (WbWriteR),
        .Stall         (Stall),
        .Busy          (Busy),
        .Underflow     (Underflow)
    );

    always #5 Clk = ~Clk;

    // Writes to r still outstanding after this cycle's writeback retires one.
    function automatic int remaining(input logic [4:0] r);
        int n;
        n = (r == 5'd0) ? 0 : pendM[r];
        if (n > 0 && WbRegWrite && WbWriteR == r) n = n - 1;
        return n;
    endfunction

    function automatic bit modelStall();
        bit need;
        need = 1'b0;
        if (IssueUse1 && remaining(IssueR1) > 0) need = 1'b1;
        if (IssueUse2 && remaining(IssueR2) > 0) need = 1'b1;
        if (IssueRegWrite && IssueDest != 5'd0 && remaining(IssueDest) >= 3) need = 1'b1;
        return IssueValid && !Flush && need;
    endfunction

    function automatic logic [31:0] modelBusy();
        logic [31:0] b;
        b = '0;
        for (int r = 1; r < 32; r++) b[r] = (pendM[r] != 0);
        return b;
    endfunction

    // Reference model: pending writes per register, updated once per edge.
    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int r = 0; r < 32; r++) pendM[r] = 0;
            underflowM = 1'b0;
        end else begin
            bit acc;
            acc = IssueValid && !Flush && !modelStall();
            for (int r = 1; r < 32; r++) begin
                int delta;
                delta = 0;
                if (WbRegWrite && WbWriteR == r) begin
                    if (pendM[r] == 0) underflowM = 1'b1;
                    else delta = delta - 1;
                end
                if (acc && IssueRegWrite && IssueDest == r) delta = delta + 1;
                pendM[r] = Flush ? 0 : pendM[r] + delta;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        #2;
        if (checking) begin
            checkOutput("model Stall", {31'd0, Stall}, {31'd0, modelStall()});
            checkOutput("model Busy", Busy, modelBusy());
            checkOutput("model Underflow", {31'd0, Underflow}, {31'd0, underflowM});
        end
    end

    task automatic applyStimulus(input logic v, input logic u1, input logic [4:0] r1,
                                 input logic u2, input logic [4:0] r2,
                                 input logic rw, input logic [4:0] dst,
                                 input logic wb, input logic [4:0] wbr,
                                 input logic fl);
        @(negedge Clk);
        IssueValid = v; IssueUse1 = u1; IssueR1 = r1; IssueUse2 = u2; IssueR2 = r2;
        IssueRegWrite = rw; IssueDest = dst; WbRegWrite = wb; WbWriteR = wbr; Flush = fl;
        #2;
    endtask

    task automatic idle(input logic wb, input logic [4:0] wbr);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, wb, wbr, 0);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        checking   = 1'b0;
        underflowM = 1'b0;
        for (int r = 0; r < 32; r++) pendM[r] = 0;
        Rst = 1'b1; Flush = 0; IssueValid = 0; IssueUse1 = 0; IssueUse2 = 0;
        IssueR1 = 0; IssueR2 = 0; IssueRegWrite = 0; IssueDest = 0;
        WbRegWrite = 0; WbWriteR = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        checking = 1'b1;

        // Reset state and a hazard-free issue.
        idle(0, 0);
        checkOutput("reset Busy", Busy, 32'h0);
        checkOutput("reset Stall", {31'd0, Stall}, 32'd0);
        checkOutput("reset Underflow", {31'd0, Underflow}, 32'd0);
        applyStimulus(1, 1, 3, 1, 4, 0, 0, 0, 0, 0);
        checkOutput("clean issue Stall", {31'd0, Stall}, 32'd0);

        // RAW on r5 with same-cycle writeback bypass.
        applyStimulus(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        checkOutput("issue r5 Stall", {31'd0, Stall}, 32'd0);
        applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r5 Busy", {31'd0, Busy[5]}, 32'd1);
        checkOutput("r5 raw Stall", {31'd0, Stall}, 32'd1);
        applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r5 raw Stall again", {31'd0, Stall}, 32'd1);
        applyStimulus(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
        checkOutput("r5 bypass Stall", {31'd0, Stall}, 32'd0);
        idle(0, 0);
        checkOutput("r5 retired Busy", {31'd0, Busy[5]}, 32'd0);

        // Saturation on r7.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
            checkOutput("fill r7 Stall", {31'd0, Stall}, 32'd0);
        end
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        checkOutput("r7 saturated Stall", {31'd0, Stall}, 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
        checkOutput("r7 sat with wb Stall", {31'd0, Stall}, 32'd0);
        idle(1, 7);
        checkOutput("r7 busy at 3", {31'd0, Busy[7]}, 32'd1);
        idle(1, 7);
        idle(1, 7);
        checkOutput("r7 busy at 1", {31'd0, Busy[7]}, 32'd1);
        idle(0, 0);
        checkOutput("r7 drained Busy", {31'd0, Busy[7]}, 32'd0);
        checkOutput("r7 no Underflow", {31'd0, Underflow}, 32'd0);

        // Register 0 is inert.
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("r0 Stall", {31'd0, Stall}, 32'd0);
        idle(1, 0);
        checkOutput("r0 Busy", Busy, 32'h0);
        idle(0, 0);
        checkOutput("r0 wb Underflow", {31'd0, Underflow}, 32'd0);

        // Underflow is sticky through Flush.
        idle(1, 9);
        idle(0, 0);
        checkOutput("r9 Underflow", {31'd0, Underflow}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0, 0);
        checkOutput("Underflow after Flush", {31'd0, Underflow}, 32'd1);

        // Flush squashes pending writes and the issue in that cycle.
        applyStimulus(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 31, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
        checkOutput("pre-flush Busy", Busy, 32'h8000_0044);
        checkOutput("flush Stall", {31'd0, Stall}, 32'd0);
        idle(0, 0);
        checkOutput("post-flush Busy", Busy, 32'h0);

        // Asynchronous reset between edges.
        applyStimulus(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        idle(0, 0);
        checkOutput("r2 Busy", {31'd0, Busy[2]}, 32'd1);
        #1 Rst = 1'b1;
        #1;
        checkOutput("async reset Busy", Busy, 32'h0);
        checkOutput("async reset Underflow", {31'd0, Underflow}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;

        // Randomized traffic on a small register window to provoke hazards.
        for (int c = 0; c < 2000; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                          $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                          $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)),
                          $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                          $urandom_range(0, 39) == 0);
        end

        idle(0, 0);
        @(negedge Clk);
        #4;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
